// File: rtl/fetch_seq_pkg.sv
// Shared definitions for the fetch sequencer: FSM encoding and the
// register-file indices used by fetch, decode and register-file muxing.
package fetch_seq_pkg;

  typedef enum logic [2:0] {
    ST_INIT_LO = 3'd0,
    ST_INIT_HI = 3'd1,
    ST_FETCH   = 3'd2,
    ST_INC_LO  = 3'd3,
    ST_INC_HI  = 3'd4,
    ST_HOLD    = 3'd5,
    ST_JMP_LO  = 3'd6,
    ST_JMP_HI  = 3'd7
  } fetch_state_t;

  localparam logic [3:0] PCL_IDX   = 4'd10;
  localparam logic [3:0] PCH_IDX   = 4'd11;
  localparam logic [2:0] PC_PAIR_IDX = 3'd5;
  localparam int unsigned NUM_REGS = 12;

endpackage

// File: rtl/fetch_seq.sv
// Instruction-fetch sequencer: initialises PC, fetches one opcode per loop,
// writes PC+1 (or a jump target) back through the register-file load port
// and presents the opcode to the decoder with a valid/ready handshake.
module fetch_seq
  import fetch_seq_pkg::*;
#(
  parameter logic [15:0] RESET_VECTOR = 16'h0000,
  parameter logic [2:0]  PC_PAIR      = PC_PAIR_IDX,
  parameter logic [3:0]  PCL_REG      = PCL_IDX,
  parameter logic [3:0]  PCH_REG      = PCH_IDX
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic [15:0] i_rf_addr,
  output logic [2:0]  o_rf_addr_sel,
  output logic [7:0]  o_rf_dat,
  output logic        o_rf_load,
  output logic [3:0]  o_rf_load_sel,
  output logic        o_busy,
  output logic        o_mem_rd,
  input  logic        i_mem_ack,
  input  logic [7:0]  i_mem_dat,
  output logic [7:0]  o_ir,
  output logic        o_ir_valid,
  input  logic        i_ir_ready,
  input  logic        i_jump,
  input  logic [15:0] i_jump_addr
);

  fetch_state_t state_q, state_d;
  logic [15:0]  pc_next_q, pc_next_d;
  logic [7:0]   ir_q, ir_d;
  logic         rf_load_d;

  // State, PC shadow and instruction register.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q   <= ST_INIT_LO;
      pc_next_q <= '0;
      ir_q      <= '0;
    end else begin
      state_q   <= state_d;
      pc_next_q <= pc_next_d;
      ir_q      <= ir_d;
    end
  end

  // Next-state logic and output decode from state and registered data.
  always_comb begin
    state_d       = state_q;
    pc_next_d     = pc_next_q;
    ir_d          = ir_q;
    o_rf_addr_sel = PC_PAIR;
    o_rf_dat      = '0;
    rf_load_d     = 1'b0;
    o_rf_load_sel = '0;
    o_busy        = 1'b1;
    o_mem_rd      = 1'b0;
    o_ir_valid    = 1'b0;

    unique case (state_q)
      ST_INIT_LO: begin
        rf_load_d     = 1'b1;
        o_rf_load_sel = PCL_REG;
        o_rf_dat      = RESET_VECTOR[7:0];
        state_d       = ST_INIT_HI;
      end
      ST_INIT_HI: begin
        rf_load_d     = 1'b1;
        o_rf_load_sel = PCH_REG;
        o_rf_dat      = RESET_VECTOR[15:8];
        state_d       = ST_FETCH;
      end
      ST_FETCH: begin
        o_mem_rd = 1'b1;
        if (i_mem_ack) begin
          ir_d      = i_mem_dat;
          pc_next_d = i_rf_addr + 16'd1;
          state_d   = ST_INC_LO;
        end
      end
      ST_INC_LO, ST_JMP_LO: begin
        rf_load_d     = 1'b1;
        o_rf_load_sel = PCL_REG;
        o_rf_dat      = pc_next_q[7:0];
        state_d       = (state_q == ST_INC_LO) ? ST_INC_HI : ST_JMP_HI;
      end
      ST_INC_HI: begin
        rf_load_d     = 1'b1;
        o_rf_load_sel = PCH_REG;
        o_rf_dat      = pc_next_q[15:8];
        state_d       = ST_HOLD;
      end
      ST_JMP_HI: begin
        rf_load_d     = 1'b1;
        o_rf_load_sel = PCH_REG;
        o_rf_dat      = pc_next_q[15:8];
        state_d       = ST_FETCH;
      end
      ST_HOLD: begin
        o_rf_addr_sel = '0;
        o_busy        = 1'b0;
        o_ir_valid    = 1'b1;
        if (i_ir_ready) begin
          if (i_jump) begin
            pc_next_d = i_jump_addr;
            state_d   = ST_JMP_LO;
          end else begin
            state_d   = ST_FETCH;
          end
        end
      end
      default: state_d = ST_INIT_LO;
    endcase
  end

  // The reset state itself decodes a load, so the strobe is qualified with
  // reset to keep the register file untouched while reset is held.
  assign o_rf_load = rf_load_d & i_reset_n;
  assign o_ir      = ir_q;

endmodule

// File: tb/tb_fetch_seq.sv
// Scoreboard bench for fetch_seq: a register-file and memory model surround
// the DUT; stimulus pushes expected loads, fetch addresses and opcodes, and
// a monitor pops and compares them as the DUT presents them.
module tb_fetch_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] rf_addr;
  logic [2:0]  rf_addr_sel;
  logic [7:0]  rf_dat;
  logic        rf_load;
  logic [3:0]  rf_load_sel;
  logic        busy;
  logic        mem_rd;
  logic        mem_ack;
  logic [7:0]  mem_dat;
  logic [7:0]  ir;
  logic        ir_valid;
  logic        ir_ready;
  logic        jump;
  logic [15:0] jump_addr;

  int unsigned errors = 0;
  int unsigned checks = 0;

  logic [7:0]  rf [12];
  int unsigned wait_cfg;
  int unsigned wcnt = 0;
  logic        force_ack;

  logic [11:0] load_q [$];
  logic [15:0] addr_q [$];
  logic [7:0]  ir_exp_q [$];

  always #5 clk = ~clk;

  fetch_seq #(.RESET_VECTOR(16'h0100)) dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_rf_addr(rf_addr),
    .o_rf_addr_sel(rf_addr_sel), .o_rf_dat(rf_dat), .o_rf_load(rf_load),
    .o_rf_load_sel(rf_load_sel), .o_busy(busy), .o_mem_rd(mem_rd),
    .i_mem_ack(mem_ack), .i_mem_dat(mem_dat), .o_ir(ir),
    .o_ir_valid(ir_valid), .i_ir_ready(ir_ready), .i_jump(jump),
    .i_jump_addr(jump_addr)
  );

  function automatic logic [7:0] mem_byte(input logic [15:0] a);
    case (a)
      16'h0100: return 8'hA5;
      16'h0101: return 8'h3C;
      16'hFFFF: return 8'hEE;
      16'h0000: return 8'h11;
      16'h1234: return 8'h77;
      default:  return 8'h00;
    endcase
  endfunction

  // Register file model: PC pair is regs 11:10.
  always @(posedge clk) begin
    if (rf_load && rf_load_sel < 4'd12) rf[rf_load_sel] <= rf_dat;
  end
  assign rf_addr = (rf_addr_sel == 3'd5) ? {rf[11], rf[10]} : 16'h0000;

  // Memory model with configurable wait states.
  always @(posedge clk) begin
    if (mem_rd && !mem_ack) wcnt <= wcnt + 1;
    else                    wcnt <= 0;
  end
  assign mem_ack = force_ack | (mem_rd && (wcnt >= wait_cfg));
  assign mem_dat = mem_ack ? mem_byte(rf_addr) : 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: compare every load, fetch address and accepted opcode.
  always @(negedge clk) begin
    if (rf_load) begin
      if (load_q.size() == 0) chk("unexpected_load", {20'd0, rf_load_sel, rf_dat}, 32'hFFFF_FFFF);
      else chk("rf_load", {20'd0, rf_load_sel, rf_dat}, {20'd0, load_q.pop_front()});
    end
    if (mem_rd && mem_ack) begin
      if (addr_q.size() == 0) chk("unexpected_fetch", {16'd0, rf_addr}, 32'hFFFF_FFFF);
      else begin
        chk("fetch_sel", {29'd0, rf_addr_sel}, 32'd5);
        chk("fetch_addr", {16'd0, rf_addr}, {16'd0, addr_q.pop_front()});
      end
    end
    if (ir_valid && ir_ready) begin
      if (ir_exp_q.size() == 0) chk("unexpected_ir", {24'd0, ir}, 32'hFFFF_FFFF);
      else chk("ir_handshake", {24'd0, ir}, {24'd0, ir_exp_q.pop_front()});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_fetch(input logic [15:0] a, input logic [7:0] op, input logic [15:0] pcn);
    addr_q.push_back(a);
    ir_exp_q.push_back(op);
    load_q.push_back({4'd10, pcn[7:0]});
    load_q.push_back({4'd11, pcn[15:8]});
  endtask

  task automatic push_pc(input logic [15:0] v);
    load_q.push_back({4'd10, v[7:0]});
    load_q.push_back({4'd11, v[15:8]});
  endtask

  task automatic wait_hold();
    int unsigned g = 0;
    while (!ir_valid && g < 100) begin
      tick();
      g++;
    end
    chk("hold_timeout", {31'd0, ir_valid}, 32'd1);
  endtask

  task automatic accept(input logic j, input logic [15:0] a);
    ir_ready  = 1'b1;
    jump      = j;
    jump_addr = a;
    tick();
    ir_ready  = 1'b0;
    jump      = 1'b0;
  endtask

  initial begin
    int unsigned n;
    rst_n = 1'b0; ir_ready = 1'b0; jump = 1'b0; jump_addr = 16'h0;
    wait_cfg = 0; force_ack = 1'b0;

    push_pc(16'h0100);
    push_fetch(16'h0100, 8'hA5, 16'h0101);
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {27'd0, busy, mem_rd, ir_valid, rf_load, 1'b0}, {27'd0, 5'b10000});
    chk("reset_ir", {24'd0, ir}, 32'd0);
    rst_n = 1'b1;
    wait_hold();
    chk("pc_after_first", {16'd0, rf[11], rf[10]}, 32'h0101);
    chk("ir_first", {24'd0, ir}, 32'hA5);

    // Backpressure: opcode held, bus released, no memory traffic.
    for (int i = 0; i < 5; i++) begin
      chk("backpressure", {19'd0, ir_valid, ir, busy, mem_rd, rf_load, 1'b0},
          {19'd0, 1'b1, 8'hA5, 4'b0000});
      tick();
    end

    // Three wait states on the next fetch.
    wait_cfg = 3;
    push_fetch(16'h0101, 8'h3C, 16'h0102);
    accept(1'b0, 16'h0);
    chk("fetch_after_ready", {31'd0, mem_rd}, 32'd1);
    n = 0;
    while (mem_rd && !mem_ack && n < 20) begin
      chk("wait_quiet", {23'd0, rf_load, ir}, {23'd0, 1'b0, 8'hA5});
      tick();
      n++;
    end
    chk("wait_cycles", n, 32'd3);
    tick();
    chk("ir_capture", {24'd0, ir}, 32'h3C);
    wait_cfg = 0;
    wait_hold();

    // Jump to FFFF then fetch there: PC wraps to 0000.
    push_pc(16'hFFFF);
    push_fetch(16'hFFFF, 8'hEE, 16'h0000);
    accept(1'b1, 16'hFFFF);
    wait_hold();
    chk("pc_wrap", {16'd0, rf[11], rf[10]}, 32'h0000);

    push_fetch(16'h0000, 8'h11, 16'h0001);
    accept(1'b0, 16'h0);
    wait_hold();
    chk("pc_after_wrap", {16'd0, rf[11], rf[10]}, 32'h0001);

    push_pc(16'h1234);
    push_fetch(16'h1234, 8'h77, 16'h1235);
    accept(1'b1, 16'h1234);
    wait_hold();
    chk("pc_after_jump", {16'd0, rf[11], rf[10]}, 32'h1235);

    // Reset in the middle of a waited fetch.
    wait_cfg = 5;
    accept(1'b0, 16'h0);
    tick();
    tick();
    chk("pre_reset_rd", {31'd0, mem_rd}, 32'd1);
    #2;
    rst_n = 1'b0;
    force_ack = 1'b1;
    #1;
    chk("async_rd_drop", {29'd0, mem_rd, busy, ir_valid}, {29'd0, 3'b010});
    tick();
    tick();
    chk("reset_hold", {23'd0, rf_load, ir}, 32'd0);
    force_ack = 1'b0;
    wait_cfg = 0;
    push_pc(16'h0100);
    push_fetch(16'h0100, 8'hA5, 16'h0101);
    rst_n = 1'b1;
    wait_hold();
    chk("ir_after_reset", {24'd0, ir}, 32'hA5);

    wait_cfg = 30;
    accept(1'b0, 16'h0);
    repeat (3) tick();
    chk("load_q_empty", load_q.size(), 32'd0);
    chk("addr_q_empty", addr_q.size(), 32'd0);
    chk("ir_q_empty", ir_exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_seq.md
Name: fetch_seq

Overview:
Instruction-fetch sequencer sitting directly upstream of the register file. It drives the register file's load port, load select and address-pair select. It initialises PC (regs 10/11) after reset and fetches one opcode byte per cycle of its FSM from memory at PC. It writes PC+1 back through the register file load port and hands the opcode to the decoder via a valid/ready handshake. It also accepts a jump target from the decoder and loads it into PC before the next fetch.

Parameters:
RESET_VECTOR, 16'h0000, PC value written after reset
PC_PAIR, 3'd5, register-pair index of PC on the address-select port
PCL_REG, 4'd10, register index of PC low byte
PCH_REG, 4'd11, register index of PC high byte

Ports:
i_clk  in  1  clock, rising edge
i_reset_n  in  1  asynchronous active-low reset
i_rf_addr  in  16  register-file address-pair output (current PC when o_rf_addr_sel=PC_PAIR)
o_rf_addr_sel  out  3  register-pair select to register file
o_rf_dat  out  8  load data to register file
o_rf_load  out  1  register-file load strobe
o_rf_load_sel  out  4  register-file load target
o_busy  out  1  1 = fetch_seq owns the register-file control ports; decoder muxes its own controls in when 0
o_mem_rd  out  1  memory read request (address = i_rf_addr)
i_mem_ack  in  1  memory read acknowledge, data valid same cycle
i_mem_dat  in  8  memory read data
o_ir  out  8  fetched opcode
o_ir_valid  out  1  opcode valid
i_ir_ready  in  1  decoder accepts opcode
i_jump  in  1  with i_ir_ready: load i_jump_addr into PC instead of continuing
i_jump_addr  in  16  jump target

Behaviour:
- Reset (async, i_reset_n=0): state=INIT_LO, o_ir=0, pc_next=0. All registered outputs are 0: o_ir_valid, o_mem_rd, o_rf_load. o_busy=1 during reset and init.
- All outputs are decoded from state plus registered pc_next/IR. No combinational path from i_mem_dat to outputs.
- INIT_LO: o_rf_load=1, sel=PCL_REG, dat=RESET_VECTOR[7:0]. Next state INIT_HI.
- INIT_HI: o_rf_load=1, sel=PCH_REG, dat=RESET_VECTOR[15:8]. Next state FETCH.
- FETCH: o_rf_addr_sel=PC_PAIR, o_mem_rd=1, held until i_mem_ack. On ack (same cycle allowed, zero wait):
  - IR <= i_mem_dat
  - pc_next <= i_rf_addr + 1, 16-bit, 16'hFFFF wraps to 16'h0000
  - next state INC_LO
- INC_LO: load PCL_REG with pc_next[7:0]. Next state INC_HI.
- INC_HI: load PCH_REG with pc_next[15:8]. Always written, even without carry. Next state HOLD.
- HOLD: o_ir_valid=1, o_busy=0, o_rf_load=0.
  - i_ir_ready=1 & i_jump=0 → FETCH.
  - i_ir_ready=1 & i_jump=1 → pc_next <= i_jump_addr; next state JMP_LO.
  - i_ir_ready=0 → stay; IR stable; i_jump ignored.
- JMP_LO / JMP_HI: same as INC_LO / INC_HI using pc_next. Next state FETCH.
- o_rf_addr_sel=PC_PAIR in every state except HOLD. In HOLD it is 0 and is don't-care to the decoder mux.
- i_mem_ack outside FETCH: ignored.
- Minimum loop without jump: FETCH(1, zero-wait) + INC_LO + INC_HI + HOLD = 4 cycles per opcode.
- Reset asserted mid-operation: immediate return to INIT_LO. Any pending memory request is dropped (o_mem_rd=0 asynchronously).

Decomposition:
- Shared package holds:
  - state encoding enum (INIT_LO, INIT_HI, FETCH, INC_LO, INC_HI, HOLD, JMP_LO, JMP_HI), 3-bit
  - register index constants: PCL=10, PCH=11, PC_PAIR=5, register count 12
- These are reused by the decoder and register-file muxing.
- No sub-module. The 16-bit incrementer and output decode are inline.

Test Plan:
- Reset with RESET_VECTOR=16'h0100, memory returning 8'hA5 at 0x0100:
  - cycles 1-2: loads (10,8'h00) then (11,8'h01)
  - o_mem_rd with addr_sel=5
  - o_ir=8'hA5, o_ir_valid=1
  - PC reg pair then reads 16'h0101
- Wait states: i_mem_ack delayed 3 cycles → o_mem_rd held 3 cycles, IR captured only on the ack cycle, no rf loads during the wait.
- Wrap: PC=16'hFFFF, fetch → writes (10,8'h00) and (11,8'h00); next fetch at 0x0000.
- Backpressure: i_ir_ready=0 for 5 cycles in HOLD → o_ir_valid stays 1, o_ir stable, o_busy=0, no mem read. Ready=1 → FETCH next cycle.
- Jump: in HOLD drive i_ir_ready=1, i_jump=1, i_jump_addr=16'h1234 → loads (10,8'h34), (11,8'h12); next fetch address 0x1234.
- Async reset asserted during FETCH wait → o_mem_rd drops immediately. After release: INIT_LO, RESET_VECTOR rewritten, ack arriving during reset ignored.
